sel_pipe_mux: RTL

Parametrised, registered N-way selector with valid/ready flow control. It generalises the 2:1 register-address multiplexer into an N-input, W-bit pipeline stage. It is used between decode and register-file writeback to pick the destination index (rd/rt/link), and anywhere an operand select must be cut for timing. A two-entry skid buffer gives full throughput under backpressure, and out-of-range selects are flagged.

---
 rtl/sel_pipe_pkg.sv | 10 +
 rtl/sel_skid_reg.sv | 49 ++++
 rtl/sel_pipe_mux.sv | 77 +++++++
 3 files changed

// File: rtl/sel_pipe_pkg.sv
// Shared constants and helpers for the registered N-way selector.
package sel_pipe_pkg;

  localparam int ERR_CNT_W = 8;

  function automatic int sel_w_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sel_skid_reg.sv
// Two-entry valid/ready skid buffer on an opaque payload.
module sel_skid_reg #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         or_v;
  logic         sk_v;
  logic [W-1:0] or_d;
  logic [W-1:0] sk_d;
  logic         in_xfer;

  // in_ready comes straight from a flop, so out_ready never reaches it
  assign in_ready  = !sk_v;
  assign in_xfer   = in_valid && !sk_v;
  assign out_data  = or_d;
  assign out_valid = or_v;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_v <= 1'b0;
      sk_v <= 1'b0;
      or_d <= '0;
      sk_d <= '0;
    end else if (!or_v || out_ready) begin
      if (sk_v) begin
        or_v <= 1'b1;
        or_d <= sk_d;
        sk_v <= 1'b0;
      end else begin
        or_v <= in_xfer;
        if (in_xfer)
          or_d <= in_data;
      end
    end else if (in_xfer) begin
      sk_v <= 1'b1;
      sk_d <= in_data;
    end
  end

endmodule

// File: rtl/sel_pipe_mux.sv
// Registered N-way selector with skid buffer and select-range check.
// Optional saturating error counter: define SEL_ERR_CNT_EN.
module sel_pipe_mux
  import sel_pipe_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = sel_w_of(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
`ifdef SEL_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0]    err_cnt,
`endif
  input  logic                    out_ready
);

  typedef logic [WIDTH-1:0] data_t;
  typedef struct packed {
    logic  err;
    data_t data;
  } entry_t;

  entry_t cap;
  entry_t held;
  logic   sel_bad;

  generate
    if ((1 << SEL_W) == NUM_IN) begin : g_pow2
      assign sel_bad = 1'b0;
    end else begin : g_range
      assign sel_bad = (int'(in_sel) >= NUM_IN);
    end
  endgenerate

  // an out-of-range select matches no channel and leaves data at zero
  always_comb begin
    cap = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (in_sel == SEL_W'(k))
        cap.data = in_data[k*WIDTH +: WIDTH];
    cap.err = sel_bad;
  end

  sel_skid_reg #(
    .W($bits(entry_t))
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (cap),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (held),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_data    = held.data;
  assign out_sel_err = held.err;

`ifdef SEL_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (in_valid && in_ready && sel_bad && err_cnt != '1)
      err_cnt <= err_cnt + 1'b1;
  end
`endif

endmodule
